stage_seq: RTL and testbench
============================

# stage_seq

Parametrised multi-cycle stage sequencer, the successor to the fixed IF/EX/MEM controller. It walks each instruction through IF, EX, optional MEM and optional WB, and raises the per-stage register write enables. Unlike the fixed version, it runs real request/acknowledge handshakes with instruction and data memory, and it supports a configurable wait-state timeout, stall, flush and a retired-instruction counter. It sits between the datapath registers (IR, PC, PSR, RF, EX/MEM, MEM/WB latches) and the memory interfaces.

## Interface
- WB_EN, 0: 1 inserts a separate WB stage after MEM; 0 writes back directly from MEM.
- TIMEOUT, 15: maximum consecutive un-acked, un-stalled wait cycles in IF or MEM before abort; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must satisfy TIMEOUT < 2^CNT_W.
- RET_W, 16: width of the retired-instruction counter.
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_inst  in  1  the instruction in EX needs a data-memory access.
- imem_ack  in  1  instruction memory has data valid this cycle.
- dmem_ack  in  1  data memory access completes this cycle.
- stall  in  1  hold the current stage and suppress all write enables.
- flush  in  1  abandon the current instruction and return to IF.
- imem_req, dmem_req  out  1 each  memory requests.
- IR_Wen, EXtoMEM_Wen, MEMtoWB_Wen, PC_Wen, PSR_Wen, RF_Wen  out  1 each  register write enables.
- stage  out  2  current stage: IF=0, EX=1, MEM=2, WB=3.
- mem_timeout  out  1  one-cycle pulse on a timeout abort.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- retire_cnt  out  RET_W  count of retired instructions; wraps modulo 2^RET_W.

## Operation
- Registered state: stage, wait_cnt[CNT_W], retire_cnt. All other outputs are combinational from the state and the inputs.
- Priority, per cycle: flush > stall > timeout > normal.
- **flush:** next stage = IF; all Wen = 0; both req = 0; wait_cnt cleared; no retire.
- **stall:** stage and wait_cnt hold; all Wen = 0; the req of the current stage stays high; acks are ignored.
- **IF:** imem_req = 1.
  - On imem_ack: IR_Wen = 1, next stage = EX.
  - Otherwise stay in IF and increment wait_cnt.
- **EX:** always one cycle.
  - mem_inst = 1: EXtoMEM_Wen = 1, next stage = MEM.
  - mem_inst = 0: PC_Wen = PSR_Wen = RF_Wen = 1, retire, next stage = IF.
- **MEM:** dmem_req = 1.
  - On dmem_ack with WB_EN = 0: PC_Wen = RF_Wen = 1, retire, next stage = IF.
  - On dmem_ack with WB_EN = 1: MEMtoWB_Wen = 1, next stage = WB.
  - Otherwise stay in MEM and increment wait_cnt.
- **WB:** PC_Wen = RF_Wen = 1, retire, next stage = IF. Stage 3 is unreachable when WB_EN = 0; if ever entered, treat it as IF.
- **Timeout:** applies when TIMEOUT != 0, wait_cnt == TIMEOUT, and the current ack is low in IF or MEM.
  - mem_timeout = 1, next stage = IF, wait_cnt cleared.
  - In IF: no Wen; the fetch is retried.
  - In MEM: PC_Wen = 1 only, so the faulting instruction is skipped. No RF or PSR write and no retire.
- **wait_cnt:** cleared on every stage change and on flush. It saturates at TIMEOUT; it never wraps.
- **Retire:** instr_retired = 1 and retire_cnt increments by 1 on the same edge.
- A write enable never asserts in a cycle where stall or flush is high.

## Timing
- Reset (resetn low, asynchronous): stage = IF, wait_cnt = 0, retire_cnt = 0.
  - Combinational outputs during reset: imem_req = 1, every other output 0.
  - The first request is visible immediately after resetn deasserts.
- Zero-wait latency:
  - Non-memory instruction: 2 cycles (IF, EX).
  - Memory instruction: 3 cycles, or 4 with WB_EN = 1.
- Each un-acked cycle adds 1 cycle. Each stall cycle adds 1 cycle and does not advance wait_cnt.
- Timeout abort occurs in the (TIMEOUT+1)-th consecutive un-acked, un-stalled cycle of a stage.
- An ack arriving in the same cycle wait_cnt reaches TIMEOUT is honoured: normal completion, no timeout.
- Flush in the same cycle as an ack: flush wins; the ack is dropped and nothing is written.
- retire_cnt at 2^RET_W−1 plus one retire wraps to 0 with no flag.

## Test plan
- Reset, then imem_ack held high, mem_inst = 0 for 4 instructions: stage sequence 0,1,0,1…; PC_Wen/PSR_Wen/RF_Wen pulse in every EX; retire_cnt = 4 after 8 cycles.
- WB_EN = 1, mem_inst = 1, dmem_ack delayed 3 cycles: stages 0,1,2,2,2,2,3; MEMtoWB_Wen on the ack cycle; RF_Wen only in WB; 7 cycles per instruction.
- TIMEOUT = 3, dmem_ack never high: MEM for 4 cycles, mem_timeout and PC_Wen pulse on the 4th, stage returns to 0, retire_cnt unchanged. Repeat with the ack on the 4th cycle: normal completion, no timeout.
- stall high for 5 cycles mid-MEM with TIMEOUT = 3 and dmem_ack low: no timeout fires, dmem_req stays 1, all Wen 0, wait_cnt frozen.
- flush asserted in EX with mem_inst = 1: EXtoMEM_Wen = 0, next stage IF, no retire. Flush and imem_ack together in IF: IR_Wen = 0.
- RET_W = 2, 5 non-memory instructions: retire_cnt reads 1,2,3,0,1. Async reset asserted mid-MEM forces stage = 0 and retire_cnt = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/stage_seq.sv
// Multi-cycle stage sequencer: walks each instruction through IF, EX, optional MEM
// and optional WB with memory handshakes, wait-state timeout, stall, flush and retire count.
module stage_seq #(
    parameter int WB_EN   = 0,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4,
    parameter int RET_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_inst,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             stall,
    input  logic             flush,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IR_Wen,
    output logic             EXtoMEM_Wen,
    output logic             MEMtoWB_Wen,
    output logic             PC_Wen,
    output logic             PSR_Wen,
    output logic             RF_Wen,
    output logic [1:0]       stage,
    output logic             mem_timeout,
    output logic             instr_retired,
    output logic [RET_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_IF  = 2'd0,
        ST_EX  = 2'd1,
        ST_MEM = 2'd2,
        ST_WB  = 2'd3
    } stage_e;

    localparam bit              TO_ON   = (TIMEOUT != 0);
    localparam bit              WB_ON   = (WB_EN != 0);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
    // With the timeout disabled the counter still must not wrap, so it parks at all-ones.
    localparam logic [CNT_W-1:0] SAT_LIM = TO_ON ? TO_LIM : {CNT_W{1'b1}};

    stage_e           stage_q, stage_d, eff_s;
    logic [CNT_W-1:0] wait_q, wait_d, wait_inc_s;
    logic [RET_W-1:0] ret_q, ret_d;
    logic             timeout_s;

    // State registers: stage, wait counter, retired-instruction counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_q <= ST_IF;
            wait_q  <= '0;
            ret_q   <= '0;
        end else begin
            stage_q <= stage_d;
            wait_q  <= wait_d;
            ret_q   <= ret_d;
        end
    end

    // Effective stage (a stray WB without a WB stage behaves as IF) and wait helpers.
    always_comb begin
        eff_s = stage_q;
        if ((stage_q == ST_WB) && !WB_ON) begin
            eff_s = ST_IF;
        end else begin
            eff_s = stage_q;
        end
        wait_inc_s = (wait_q == SAT_LIM) ? wait_q : (wait_q + CNT_W'(1));
        timeout_s  = TO_ON && (wait_q == TO_LIM);
    end

    // Next-state and output decode; flush beats stall beats timeout beats normal flow.
    always_comb begin
        stage_d       = stage_q;
        wait_d        = wait_q;
        ret_d         = ret_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        IR_Wen        = 1'b0;
        EXtoMEM_Wen   = 1'b0;
        MEMtoWB_Wen   = 1'b0;
        PC_Wen        = 1'b0;
        PSR_Wen       = 1'b0;
        RF_Wen        = 1'b0;
        mem_timeout   = 1'b0;
        instr_retired = 1'b0;
        if (flush) begin
            stage_d = ST_IF;
            wait_d  = '0;
        end else begin
            case (eff_s)
                ST_IF: begin
                    imem_req = 1'b1;
                    if (stall) begin
                        stage_d = stage_q;
                    end else if (imem_ack) begin
                        IR_Wen  = 1'b1;
                        stage_d = ST_EX;
                        wait_d  = '0;
                    end else if (timeout_s) begin
                        mem_timeout = 1'b1;
                        stage_d     = ST_IF;
                        wait_d      = '0;
                    end else begin
                        wait_d = wait_inc_s;
                    end
                end
                ST_EX: begin
                    if (stall) begin
                        stage_d = stage_q;
                    end else if (mem_inst) begin
                        EXtoMEM_Wen = 1'b1;
                        stage_d     = ST_MEM;
                        wait_d      = '0;
                    end else begin
                        PC_Wen        = 1'b1;
                        PSR_Wen       = 1'b1;
                        RF_Wen        = 1'b1;
                        instr_retired = 1'b1;
                        ret_d         = ret_q + RET_W'(1);
                        stage_d       = ST_IF;
                        wait_d        = '0;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    if (stall) begin
                        stage_d = stage_q;
                    end else if (dmem_ack && WB_ON) begin
                        MEMtoWB_Wen = 1'b1;
                        stage_d     = ST_WB;
                        wait_d      = '0;
                    end else if (dmem_ack) begin
                        PC_Wen        = 1'b1;
                        RF_Wen        = 1'b1;
                        instr_retired = 1'b1;
                        ret_d         = ret_q + RET_W'(1);
                        stage_d       = ST_IF;
                        wait_d        = '0;
                    end else if (timeout_s) begin
                        // Skip the faulting instruction: advance PC only, nothing retires.
                        PC_Wen      = 1'b1;
                        mem_timeout = 1'b1;
                        stage_d     = ST_IF;
                        wait_d      = '0;
                    end else begin
                        wait_d = wait_inc_s;
                    end
                end
                ST_WB: begin
                    if (stall) begin
                        stage_d = stage_q;
                    end else begin
                        PC_Wen        = 1'b1;
                        RF_Wen        = 1'b1;
                        instr_retired = 1'b1;
                        ret_d         = ret_q + RET_W'(1);
                        stage_d       = ST_IF;
                        wait_d        = '0;
                    end
                end
                default: begin
                    stage_d = ST_IF;
                    wait_d  = '0;
                end
            endcase
        end
    end

    assign stage      = stage_q;
    assign retire_cnt = ret_q;

endmodule

// File: tb/tb_stage_seq.sv
// Directed bench for stage_seq: dut A (no WB, TIMEOUT=3) and dut B (WB stage,
// timeout disabled, 2-bit retire counter) on a shared clock and reset.
module tb_stage_seq;

    // Output vector order: imem_req dmem_req IR EXtoMEM MEMtoWB PC PSR RF mem_timeout instr_retired
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_IFW  = 10'b1000000000;
    localparam logic [9:0] O_IFA  = 10'b1010000000;
    localparam logic [9:0] O_ITO  = 10'b1000000010;
    localparam logic [9:0] O_EXN  = 10'b0000011101;
    localparam logic [9:0] O_EXM  = 10'b0001000000;
    localparam logic [9:0] O_MW   = 10'b0100000000;
    localparam logic [9:0] O_MA0  = 10'b0100010101;
    localparam logic [9:0] O_MA1  = 10'b0100100000;
    localparam logic [9:0] O_MTO  = 10'b0100010010;
    localparam logic [9:0] O_WB   = 10'b0000010101;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    logic a_mem_inst, a_imem_ack, a_dmem_ack, a_stall, a_flush;
    logic a_imem_req, a_dmem_req, a_ir, a_exm, a_mwb, a_pc, a_psr, a_rf, a_to, a_ret;
    logic [1:0]  a_stage;
    logic [15:0] a_cnt;
    logic b_mem_inst, b_imem_ack, b_dmem_ack, b_stall, b_flush;
    logic b_imem_req, b_dmem_req, b_ir, b_exm, b_mwb, b_pc, b_psr, b_rf, b_to, b_ret;
    logic [1:0]  b_stage;
    logic [1:0]  b_cnt;
    logic [9:0]  a_o, b_o;

    assign a_o = {a_imem_req, a_dmem_req, a_ir, a_exm, a_mwb, a_pc, a_psr, a_rf, a_to, a_ret};
    assign b_o = {b_imem_req, b_dmem_req, b_ir, b_exm, b_mwb, b_pc, b_psr, b_rf, b_to, b_ret};

    always #5 clk = ~clk;

    stage_seq #(.WB_EN(0), .TIMEOUT(3), .CNT_W(4), .RET_W(16)) u_a (
        .clk(clk), .resetn(resetn), .mem_inst(a_mem_inst), .imem_ack(a_imem_ack),
        .dmem_ack(a_dmem_ack), .stall(a_stall), .flush(a_flush),
        .imem_req(a_imem_req), .dmem_req(a_dmem_req), .IR_Wen(a_ir), .EXtoMEM_Wen(a_exm),
        .MEMtoWB_Wen(a_mwb), .PC_Wen(a_pc), .PSR_Wen(a_psr), .RF_Wen(a_rf),
        .stage(a_stage), .mem_timeout(a_to), .instr_retired(a_ret), .retire_cnt(a_cnt)
    );

    stage_seq #(.WB_EN(1), .TIMEOUT(0), .CNT_W(4), .RET_W(2)) u_b (
        .clk(clk), .resetn(resetn), .mem_inst(b_mem_inst), .imem_ack(b_imem_ack),
        .dmem_ack(b_dmem_ack), .stall(b_stall), .flush(b_flush),
        .imem_req(b_imem_req), .dmem_req(b_dmem_req), .IR_Wen(b_ir), .EXtoMEM_Wen(b_exm),
        .MEMtoWB_Wen(b_mwb), .PC_Wen(b_pc), .PSR_Wen(b_psr), .RF_Wen(b_rf),
        .stage(b_stage), .mem_timeout(b_to), .instr_retired(b_ret), .retire_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are driven and outputs sampled 1 time unit after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic a_step(input string tag, input logic [1:0] st, input logic [9:0] o);
        #1;
        chk({tag, "_stage"}, 32'(a_stage), 32'(st));
        chk({tag, "_out"}, 32'(a_o), 32'(o));
        tick();
    endtask

    task automatic b_step(input string tag, input logic [1:0] st, input logic [9:0] o);
        #1;
        chk({tag, "_stage"}, 32'(b_stage), 32'(st));
        chk({tag, "_out"}, 32'(b_o), 32'(o));
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        {a_mem_inst, a_imem_ack, a_dmem_ack, a_stall, a_flush} = 5'b00000;
        {b_mem_inst, b_imem_ack, b_dmem_ack, b_stall, b_flush} = 5'b00000;
        @(negedge clk);
        #1;
        chk("rst_a_stage", 32'(a_stage), 32'd0);
        chk("rst_a_out", 32'(a_o), 32'(O_IFW));
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        chk("rst_b_out", 32'(b_o), 32'(O_IFW));
        @(negedge clk);
        resetn = 1'b1;

        // Four back-to-back non-memory instructions.
        a_imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_step("nm_if", 2'd0, O_IFA);
            a_step("nm_ex", 2'd1, O_EXN);
        end
        chk("nm_cnt", 32'(a_cnt), 32'd4);

        // Zero-wait memory instruction, direct write-back from MEM.
        a_mem_inst = 1'b1;
        a_dmem_ack = 1'b1;
        a_step("mz_if", 2'd0, O_IFA);
        a_step("mz_ex", 2'd1, O_EXM);
        a_step("mz_mem", 2'd2, O_MA0);
        chk("mz_cnt", 32'(a_cnt), 32'd5);

        // dmem never acks: abort in the 4th MEM cycle, PC advances, nothing retires.
        a_dmem_ack = 1'b0;
        a_step("to_if", 2'd0, O_IFA);
        a_step("to_ex", 2'd1, O_EXM);
        a_imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) a_step("to_wait", 2'd2, O_MW);
        a_step("to_fire", 2'd2, O_MTO);
        chk("to_back_if", 32'(a_stage), 32'd0);
        chk("to_cnt", 32'(a_cnt), 32'd5);

        // Ack on the 4th MEM cycle wins over the timeout.
        a_imem_ack = 1'b1;
        a_step("ta_if", 2'd0, O_IFA);
        a_step("ta_ex", 2'd1, O_EXM);
        for (int i = 0; i < 3; i++) a_step("ta_wait", 2'd2, O_MW);
        a_dmem_ack = 1'b1;
        a_step("ta_ack", 2'd2, O_MA0);
        chk("ta_cnt", 32'(a_cnt), 32'd6);

        // Stall mid-MEM freezes wait_cnt at 2 and ignores acks.
        a_dmem_ack = 1'b0;
        a_step("st_if", 2'd0, O_IFA);
        a_step("st_ex", 2'd1, O_EXM);
        a_step("st_w0", 2'd2, O_MW);
        a_step("st_w1", 2'd2, O_MW);
        a_stall    = 1'b1;
        a_dmem_ack = 1'b1;
        for (int i = 0; i < 5; i++) a_step("st_hold", 2'd2, O_MW);
        a_stall    = 1'b0;
        a_dmem_ack = 1'b0;
        a_step("st_w2", 2'd2, O_MW);
        a_step("st_fire", 2'd2, O_MTO);
        chk("st_cnt", 32'(a_cnt), 32'd6);

        // IF timeout: fetch retried, no write enables.
        a_imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) a_step("ito_wait", 2'd0, O_IFW);
        a_step("ito_fire", 2'd0, O_ITO);
        a_step("ito_retry", 2'd0, O_IFW);

        // Flush in EX drops the memory instruction; flush with imem_ack writes nothing.
        a_imem_ack = 1'b1;
        a_step("fl_if", 2'd0, O_IFA);
        a_flush = 1'b1;
        a_step("fl_ex", 2'd1, O_NONE);
        a_step("fl_ifack", 2'd0, O_NONE);
        a_flush = 1'b0;
        chk("fl_stage", 32'(a_stage), 32'd0);
        chk("fl_cnt", 32'(a_cnt), 32'd6);

        // dut B idled in IF for the whole run with timeout disabled.
        chk("b_idle_stage", 32'(b_stage), 32'd0);
        chk("b_idle_out", 32'(b_o), 32'(O_IFW));

        // Async reset mid-MEM takes effect before the next clock edge.
        a_step("ar_if", 2'd0, O_IFA);
        a_dmem_ack = 1'b0;
        a_step("ar_ex", 2'd1, O_EXM);
        #1;
        chk("ar_pre", 32'(a_stage), 32'd2);
        resetn = 1'b0;
        #1;
        chk("ar_stage", 32'(a_stage), 32'd0);
        chk("ar_cnt", 32'(a_cnt), 32'd0);
        {a_mem_inst, a_imem_ack, a_dmem_ack} = 3'b000;
        @(negedge clk);
        resetn = 1'b1;
        #1;

        // RET_W=2 wrap: 5 non-memory instructions read 1,2,3,0,1.
        b_imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_step("rw_if", 2'd0, O_IFA);
            b_step("rw_ex", 2'd1, O_EXN);
            chk("rw_cnt", 32'(b_cnt), 32'((i + 1) % 4));
        end

        // WB stage: dmem_ack delayed 3 cycles, stages 0,1,2,2,2,2,3.
        b_mem_inst = 1'b1;
        b_step("wb_if", 2'd0, O_IFA);
        b_step("wb_ex", 2'd1, O_EXM);
        b_imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) b_step("wb_wait", 2'd2, O_MW);
        b_dmem_ack = 1'b1;
        b_step("wb_ack", 2'd2, O_MA1);
        b_dmem_ack = 1'b0;
        b_step("wb_wb", 2'd3, O_WB);
        chk("wb_back_if", 32'(b_stage), 32'd0);
        chk("wb_cnt", 32'(b_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
